joypad_scanner: RTL and testbench

- Conditions the eight raw board button inputs for the joypad register block: 2-flop synchronizer, shared-prescaler debounce, and the active-low 4-bit row mux selected by `button_sel`.
- Generates the joypad interrupt request on any high-to-low transition of the selected row.
- Sits between board pins and the FF00 register logic: drives `button_data`, consumes `button_sel`.

---
 rtl/joypad_scanner.sv | 108 ++++++++++
 tb/tb_joypad_scanner.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/joypad_scanner.sv
// Joypad front end: synchronizes and debounces the eight board buttons, muxes the active-low row, and raises the joypad interrupt.
// Optional macro JOYPAD_SOCD_EN cancels opposite directions (Right+Left, Up+Down) before the row mux.
module joypad_scanner #(
    parameter int DEBOUNCE_DIV     = 4194,
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] btn_raw,
    input  logic [1:0] button_sel,
    output logic [3:0] button_data,
    output logic       int_req,
    input  logic       int_ack,
    output logic [7:0] btn_stable
);

    localparam logic [15:0] DIV_LAST = 16'(DEBOUNCE_DIV - 1);
    localparam logic [2:0]  CNT_LAST = 3'(DEBOUNCE_SAMPLES - 1);

    logic [7:0]  sync_meta;
    logic [7:0]  btn_sync;
    logic [15:0] presc;
    logic        tick;
    logic [2:0]  cnt [8];
    logic [3:0]  dir;
    logic [3:0]  act;
    logic [3:0]  prev_data;
    logic        fall;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_meta <= '0;
            btn_sync  <= '0;
        end else begin
            sync_meta <= btn_raw;
            btn_sync  <= sync_meta;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else if (presc == DIV_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + 16'd1;
        end
    end

    assign tick = (presc == DIV_LAST);

    // A bit only flips after DEBOUNCE_SAMPLES consecutive ticks of disagreement; any agreeing tick restarts the count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
            btn_stable <= '0;
        end else if (tick) begin
            for (int i = 0; i < 8; i++) begin
                if (btn_sync[i] == btn_stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    btn_stable[i] <= btn_sync[i];
                    cnt[i]        <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 3'd1;
                end
            end
        end
    end

`ifdef JOYPAD_SOCD_EN
    always_comb begin
        dir = btn_stable[3:0];
        if (btn_stable[0] && btn_stable[1]) begin
            dir[1:0] = 2'b00;
        end
        if (btn_stable[2] && btn_stable[3]) begin
            dir[3:2] = 2'b00;
        end
    end
`else
    assign dir = btn_stable[3:0];
`endif

    assign act = btn_stable[7:4];

    // Purely combinational so a read right after a select write already sees the new row.
    assign button_data = ~(({4{~button_sel[0]}} & dir) | ({4{~button_sel[1]}} & act));

    assign fall = |(prev_data & ~button_data);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_data <= 4'hF;
            int_req   <= 1'b0;
        end else begin
            prev_data <= button_data;
            if (fall) begin
                int_req <= 1'b1;
            end else if (int_ack) begin
                int_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_joypad_scanner.sv
// Directed self-checking bench for joypad_scanner with DEBOUNCE_DIV=4, DEBOUNCE_SAMPLES=3.
module tb_joypad_scanner;

    logic       clock;
    logic       reset;
    logic [7:0] btn_raw;
    logic [1:0] button_sel;
    logic [3:0] button_data;
    logic       int_req;
    logic       int_ack;
    logic [7:0] btn_stable;

    int checks   = 0;
    int failures = 0;

    joypad_scanner #(
        .DEBOUNCE_DIV    (4),
        .DEBOUNCE_SAMPLES(3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .button_sel (button_sel),
        .button_data(button_data),
        .int_req    (int_req),
        .int_ack    (int_ack),
        .btn_stable (btn_stable)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Bounded wait; the caller checks btn_stable afterwards so a timeout shows up as a failure.
    task automatic wait_stable(input logic [7:0] target, input int budget, output int cycles);
        cycles = 0;
        while (btn_stable !== target && cycles < budget) begin
            step(1);
            cycles++;
        end
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        btn_raw    = 8'h00;
        button_sel = 2'b10;
        int_ack    = 1'b0;
        step(3);
        reset = 1'b1;
        step(1);
        checks++;
        if (button_data !== 4'hF) begin
            failures++;
            $display("[TB] FAIL reset_data actual=%h expected=%h", button_data, 4'hF);
        end
        checks++;
        if (int_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_int actual=%b expected=0", int_req);
        end
        checks++;
        if (btn_stable !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_stable actual=%h expected=00", btn_stable);
        end
    endtask

    task automatic test_press();
        int cyc;
        button_sel = 2'b01;
        btn_raw    = 8'h10;
        wait_stable(8'h10, 20, cyc);
        checks++;
        if (btn_stable !== 8'h10) begin
            failures++;
            $display("[TB] FAIL press_stable actual=%h expected=10", btn_stable);
        end
        checks++;
        if (cyc < 11 || cyc > 15) begin
            failures++;
            $display("[TB] FAIL press_latency actual=%0d expected=11..15", cyc);
        end
        checks++;
        if (button_data !== 4'hE) begin
            failures++;
            $display("[TB] FAIL press_data actual=%h expected=e", button_data);
        end
        checks++;
        if (int_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL press_int_early actual=%b expected=0", int_req);
        end
        step(1);
        checks++;
        if (int_req !== 1'b1) begin
            failures++;
            $display("[TB] FAIL press_int actual=%b expected=1", int_req);
        end
        pulse_ack();
        checks++;
        if (int_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL press_ack actual=%b expected=0", int_req);
        end
    endtask

    task automatic test_glitch();
        int cyc;
        btn_raw = 8'h00;
        wait_stable(8'h00, 20, cyc);
        checks++;
        if (btn_stable !== 8'h00 || int_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL release actual=%h/%b expected=00/0", btn_stable, int_req);
        end
        btn_raw = 8'h10;
        step(8);
        btn_raw = 8'h00;
        step(20);
        checks++;
        if (btn_stable !== 8'h00) begin
            failures++;
            $display("[TB] FAIL glitch_stable actual=%h expected=00", btn_stable);
        end
        checks++;
        if (int_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL glitch_int actual=%b expected=0", int_req);
        end
    endtask

    task automatic test_select_exposes();
        int cyc;
        button_sel = 2'b11;
        btn_raw    = 8'h08;
        wait_stable(8'h08, 20, cyc);
        step(2);
        checks++;
        if (button_data !== 4'hF || int_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hidden_down actual=%h/%b expected=f/0", button_data, int_req);
        end
        button_sel = 2'b10;
        #1;
        checks++;
        if (button_data !== 4'h7) begin
            failures++;
            $display("[TB] FAIL expose_data actual=%h expected=7", button_data);
        end
        step(1);
        checks++;
        if (int_req !== 1'b1) begin
            failures++;
            $display("[TB] FAIL expose_int actual=%b expected=1", int_req);
        end
        pulse_ack();
        button_sel = 2'b11;
        #1;
        checks++;
        if (button_data !== 4'hF) begin
            failures++;
            $display("[TB] FAIL deselect_data actual=%h expected=f", button_data);
        end
        step(3);
        checks++;
        if (int_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL deselect_int actual=%b expected=0", int_req);
        end
    endtask

    task automatic test_set_wins();
        button_sel = 2'b10;
        int_ack    = 1'b1;
        step(1);
        int_ack = 1'b0;
        checks++;
        if (int_req !== 1'b1) begin
            failures++;
            $display("[TB] FAIL set_wins actual=%b expected=1", int_req);
        end
        pulse_ack();
    endtask

    task automatic test_row_mux();
        int cyc;
        btn_raw = 8'h21;
        wait_stable(8'h21, 20, cyc);
        button_sel = 2'b00;
        #1;
        checks++;
        if (button_data !== 4'hC) begin
            failures++;
            $display("[TB] FAIL mux_both actual=%h expected=c", button_data);
        end
        button_sel = 2'b01;
        #1;
        checks++;
        if (button_data !== 4'hD) begin
            failures++;
            $display("[TB] FAIL mux_act actual=%h expected=d", button_data);
        end
        button_sel = 2'b10;
        #1;
        checks++;
        if (button_data !== 4'hE) begin
            failures++;
            $display("[TB] FAIL mux_dir actual=%h expected=e", button_data);
        end
        step(1);
        pulse_ack();
    endtask

    task automatic test_socd();
        int cyc;
        logic [3:0] exp_lr;
        logic [3:0] exp_ud;
`ifdef JOYPAD_SOCD_EN
        exp_lr = 4'hF;
        exp_ud = 4'hF;
`else
        exp_lr = 4'hC;
        exp_ud = 4'h3;
`endif
        button_sel = 2'b10;
        btn_raw    = 8'h03;
        wait_stable(8'h03, 30, cyc);
        checks++;
        if (btn_stable !== 8'h03 || button_data !== exp_lr) begin
            failures++;
            $display("[TB] FAIL socd_lr actual=%h/%h expected=03/%h", btn_stable, button_data, exp_lr);
        end
        btn_raw = 8'h0C;
        wait_stable(8'h0C, 30, cyc);
        checks++;
        if (btn_stable !== 8'h0C || button_data !== exp_ud) begin
            failures++;
            $display("[TB] FAIL socd_ud actual=%h/%h expected=0c/%h", btn_stable, button_data, exp_ud);
        end
        step(1);
        pulse_ack();
    endtask

    task automatic test_reset_mid_debounce();
        int cyc;
        btn_raw = 8'h00;
        wait_stable(8'h00, 30, cyc);
        button_sel = 2'b01;
        step(2);
        pulse_ack();
        btn_raw = 8'h20;
        step(7);
        reset = 1'b0;
        #1;
        checks++;
        if (btn_stable !== 8'h00 || int_req !== 1'b0 || button_data !== 4'hF) begin
            failures++;
            $display("[TB] FAIL mid_reset actual=%h/%b/%h expected=00/0/f", btn_stable, int_req, button_data);
        end
        step(2);
        reset = 1'b1;
        step(6);
        checks++;
        if (btn_stable !== 8'h00) begin
            failures++;
            $display("[TB] FAIL requalify_early actual=%h expected=00", btn_stable);
        end
        wait_stable(8'h20, 20, cyc);
        step(1);
        checks++;
        if (btn_stable !== 8'h20 || button_data !== 4'hD || int_req !== 1'b1) begin
            failures++;
            $display("[TB] FAIL requalify actual=%h/%h/%b expected=20/d/1", btn_stable, button_data, int_req);
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_select_exposes();
        test_set_wins();
        test_row_mux();
        test_socd();
        test_reset_mid_debounce();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
